// File: rtl/regwrite_arbiter.sv
// Register-bank write arbiter: one registered grant per cycle with a one-hot ack and write strobe.
// Define REGWRITE_ARB_RR_EN for round-robin arbitration; fixed priority (index 0 highest) otherwise.
module regwrite_arbiter #(
    parameter int NREQ = 6,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    output logic [2:0]      sel,
    output logic            reg_write,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic [CNTW-1:0] wr_count
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t          state;
    logic [NREQ-1:0] eligible;
    logic            grant_vld;
    logic [2:0]      grant_idx;
    logic [NREQ-1:0] grant_oh;

    function automatic logic [NREQ-1:0] onehot(input int idx);
        onehot = NREQ'(1) << idx;
    endfunction

    function automatic logic [2:0] pick_fixed(input logic [NREQ-1:0] e);
        pick_fixed = 3'b000;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if ((e & onehot(i)) != '0) pick_fixed = 3'(i);
        end
    endfunction

    function automatic logic [2:0] pick_rr(input logic [NREQ-1:0] e, input logic [2:0] start);
        int   idx;
        logic found;
        pick_rr = 3'b000;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(start) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && ((e & onehot(idx)) != '0)) begin
                pick_rr = 3'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // The requester acked this cycle still holds req high; mask it so it is not re-granted.
    assign eligible  = req & ~ack;
    assign grant_vld = !hold && (eligible != '0);

`ifdef REGWRITE_ARB_RR_EN
    logic [2:0] rr_ptr;
    assign grant_idx = pick_rr(eligible, rr_ptr);
`else
    assign grant_idx = pick_fixed(eligible);
`endif

    assign grant_oh  = grant_vld ? onehot(int'(grant_idx)) : '0;
    assign reg_write = (state == WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= 3'b000;
            ack      <= '0;
            busy     <= 1'b0;
            wr_count <= '0;
`ifdef REGWRITE_ARB_RR_EN
            rr_ptr   <= 3'b000;
`endif
        end else begin
            busy <= (eligible & ~grant_oh) != '0;
            if (grant_vld) begin
                state    <= WRITE;
                sel      <= grant_idx;
                ack      <= grant_oh;
                wr_count <= wr_count + CNTW'(1);
`ifdef REGWRITE_ARB_RR_EN
                rr_ptr   <= (grant_idx == 3'(NREQ - 1)) ? 3'b000 : grant_idx + 3'd1;
`endif
            end else begin
                // sel keeps its last value so the destination mux output stays stable
                state <= IDLE;
                ack   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: directed scenarios plus constrained-random traffic
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_regwrite_arbiter;

    localparam int NREQ = 6;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic            hold;
    logic [2:0]      sel;
    logic            reg_write;
    logic [NREQ-1:0] ack;
    logic            busy;
    logic [CNTW-1:0] wr_count;

    regwrite_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .hold     (hold),
        .sel      (sel),
        .reg_write(reg_write),
        .ack      (ack),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      sel;
        logic            rw;
        logic [NREQ-1:0] ack;
        logic            busy;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state: last select, index acked in the current cycle (-1 none),
    // write count, last granted index, busy.
    int m_sel  = 0;
    int m_ack  = -1;
    int m_cnt  = 0;
    int m_last = NREQ - 1;
    int m_busy = 0;

    task automatic model_and_push(input logic r, input logic [NREQ-1:0] rq, input logic h);
        exp_t e;
        int   g;
        bit   elig[NREQ];
        g = -1;
        if (r) begin
            m_sel = 0; m_ack = -1; m_cnt = 0; m_last = NREQ - 1; m_busy = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) elig[i] = rq[i] && (i != m_ack);
            if (!h) begin
`ifdef REGWRITE_ARB_RR_EN
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && elig[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
`else
                for (int i = 0; i < NREQ; i++)
                    if (g < 0 && elig[i]) g = i;
`endif
            end
            m_busy = 0;
            for (int i = 0; i < NREQ; i++) if (elig[i] && i != g) m_busy = 1;
            if (g >= 0) begin
                m_sel = g; m_ack = g; m_last = g;
                m_cnt = (m_cnt + 1) % (1 << CNTW);
            end else begin
                m_ack = -1;
            end
        end
        e.sel  = 3'(m_sel);
        e.rw   = (m_ack >= 0);
        e.ack  = (m_ack >= 0) ? (NREQ'(1) << m_ack) : '0;
        e.busy = (m_busy != 0);
        e.cnt  = CNTW'(m_cnt);
        sbq.push_back(e);
    endtask

    task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic h);
        @(negedge clk);
        reset = r; req = rq; hold = h;
        model_and_push(r, rq, h);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sel",       int'(sel),       int'(e.sel));
                chk("reg_write", int'(reg_write), int'(e.rw));
                chk("ack",       int'(ack),       int'(e.ack));
                chk("busy",      int'(busy),      int'(e.busy));
                chk("wr_count",  int'(wr_count),  int'(e.cnt));
            end
        end
    end

    initial begin
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] a;
        reset = 1'b1; req = '0; hold = 1'b0;

        // Reset with every requester pending, then release
        repeat (3) step(1'b1, 6'b111111, 1'b0);
        repeat (3) step(1'b0, 6'b111111, 1'b0);
        repeat (3) step(1'b0, 6'b000000, 1'b0);

        // Single requester 3, dropped after its ack
        step(1'b1, 6'b000000, 1'b0);
        step(1'b0, 6'b001000, 1'b0);
        step(1'b0, 6'b000000, 1'b0);
        step(1'b0, 6'b000000, 1'b0);

        // Three requesters held continuously
        step(1'b1, 6'b000000, 1'b0);
        repeat (8) step(1'b0, 6'b100101, 1'b0);
        step(1'b0, 6'b000000, 1'b0);

        // Lone requester held: at most one write every other cycle
        repeat (6) step(1'b0, 6'b000010, 1'b0);
        step(1'b0, 6'b000000, 1'b0);

        // Stall with requester 4 pending
        repeat (4) step(1'b0, 6'b010000, 1'b1);
        step(1'b0, 6'b010000, 1'b0);
        step(1'b0, 6'b000000, 1'b0);

        // Reset lands on the write cycle of a requester-2 grant
        step(1'b0, 6'b000100, 1'b0);
        step(1'b1, 6'b000100, 1'b0);
        step(1'b0, 6'b000000, 1'b0);

        // Random traffic: requests persist until acked, may be re-raised; occasional stall/reset
        r = '0;
        for (int n = 0; n < 800; n++) begin
            a = (m_ack >= 0) ? (NREQ'(1) << m_ack) : '0;
            r = r & ~(a & NREQ'($urandom));
            r = r | (NREQ'($urandom) & NREQ'($urandom));
            step(($urandom_range(0, 199) == 0), r, ($urandom_range(0, 5) == 0));
        end
        repeat (4) step(1'b0, 6'b000000, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
